// File: rtl/dm_abstract_cmd.sv
// Abstract-command sequencer: runs Access Register commands over the RF/CSR debug buses.
// Optional bus watchdog enabled by defining DM_ABS_TIMEOUT_EN.
module dm_abstract_cmd #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iDmActive,
  input  logic        iHalted,
  input  logic        iCmdValid,
  input  logic [31:0] iCmd,
  input  logic [2:0]  iErrClr,
  input  logic [31:0] iData0,
  output logic [31:0] oData0,
  output logic        oData0We,
  output logic        oBusy,
  output logic [2:0]  oCmdErr,
  output logic        oRfReq,
  output logic        oRfWe,
  output logic [4:0]  oRfAddr,
  output logic [31:0] oRfWdata,
  input  logic        iRfAck,
  input  logic        iRfErr,
  input  logic [31:0] iRfRdata,
  output logic        oCsrReq,
  output logic        oCsrWe,
  output logic [11:0] oCsrAddr,
  output logic [31:0] oCsrWdata,
  input  logic        iCsrAck,
  input  logic        iCsrErr,
  input  logic [31:0] iCsrRdata
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_REQ, S_DONE} state_e;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_BUSY   = 3'd1;
  localparam logic [2:0] ERR_NOTSUP = 3'd2;
  localparam logic [2:0] ERR_EXC    = 3'd3;
  localparam logic [2:0] ERR_HALT   = 3'd4;
`ifdef DM_ABS_TIMEOUT_EN
  localparam logic [2:0] ERR_BUS    = 3'd5;
  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  state_e      state_q, state_d;
  logic [31:0] cmd_q, cmd_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic [31:0] data0_q, data0_d;
  logic        data0_we_q, data0_we_d;
  logic        busy_q, busy_d;
  logic        rf_req_q, rf_req_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_addr_q, rf_addr_d;
  logic        csr_req_q, csr_req_d;
  logic        csr_we_q, csr_we_d;
  logic [11:0] csr_addr_q, csr_addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        err_set;
  logic [2:0]  err_val;

  // Command field decode from the latched word
  logic [7:0]  cmd_type;
  logic [2:0]  aarsize;
  logic        postexec, transfer, write;
  logic [15:0] regno;
  logic        reg_is_csr, reg_is_rf;
  logic        unused_cmd_bits;

  assign cmd_type   = cmd_q[31:24];
  assign aarsize    = cmd_q[22:20];
  assign postexec   = cmd_q[18];
  assign transfer   = cmd_q[17];
  assign write      = cmd_q[16];
  assign regno      = cmd_q[15:0];
  assign reg_is_csr = (regno[15:12] == 4'h0);
  assign reg_is_rf  = (regno[15:5] == 11'h080);
  assign unused_cmd_bits = ^{cmd_q[23], cmd_q[19]};

  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;

  assign bus_ack   = rf_req_q ? iRfAck   : iCsrAck;
  assign bus_err   = rf_req_q ? iRfErr   : iCsrErr;
  assign bus_rdata = rf_req_q ? iRfRdata : iCsrRdata;

`ifdef DM_ABS_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Watchdog counts consecutive REQ cycles and restarts from zero on every entry
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == S_REQ && state_d == S_REQ) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cmderr_d   = cmderr_q & ~iErrClr;
    data0_d    = data0_q;
    data0_we_d = 1'b0;
    rf_req_d   = rf_req_q;
    rf_we_d    = rf_we_q;
    rf_addr_d  = rf_addr_q;
    csr_req_d  = csr_req_q;
    csr_we_d   = csr_we_q;
    csr_addr_d = csr_addr_q;
    wdata_d    = wdata_q;
    err_set    = 1'b0;
    err_val    = ERR_NONE;

    // A new command while one is in flight is dropped and flagged
    if (iCmdValid && state_q != S_IDLE) begin
      err_set = 1'b1;
      err_val = ERR_BUSY;
    end

    case (state_q)
      S_IDLE: begin
        if (iCmdValid && cmderr_q == ERR_NONE) begin
          state_d = S_DECODE;
          cmd_d   = iCmd;
        end
      end
      S_DECODE: begin
        state_d = S_DONE;
        if (cmd_type != 8'h00 || aarsize != 3'd2 || postexec ||
            (transfer && !reg_is_csr && !reg_is_rf)) begin
          err_set = 1'b1;
          err_val = ERR_NOTSUP;
        end else if (!iHalted) begin
          err_set = 1'b1;
          err_val = ERR_HALT;
        end else if (transfer) begin
          state_d = S_REQ;
          wdata_d = iData0;
          if (reg_is_rf) begin
            rf_req_d  = 1'b1;
            rf_we_d   = write;
            rf_addr_d = regno[4:0];
          end else begin
            csr_req_d  = 1'b1;
            csr_we_d   = write;
            csr_addr_d = regno[11:0];
          end
        end
      end
      S_REQ: begin
        if (bus_ack) begin
          state_d   = S_DONE;
          rf_req_d  = 1'b0;
          rf_we_d   = 1'b0;
          csr_req_d = 1'b0;
          csr_we_d  = 1'b0;
          if (bus_err) begin
            err_set = 1'b1;
            err_val = ERR_EXC;
          end else if (!write) begin
            data0_d    = bus_rdata;
            data0_we_d = 1'b1;
          end
        end
`ifdef DM_ABS_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = S_DONE;
          rf_req_d  = 1'b0;
          rf_we_d   = 1'b0;
          csr_req_d = 1'b0;
          csr_we_d  = 1'b0;
          err_set   = 1'b1;
          err_val   = ERR_BUS;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Errors are sticky: only the first one since the last clear is recorded
    if (err_set && cmderr_q == ERR_NONE) cmderr_d = err_val;

    if (!iDmActive) begin
      state_d    = S_IDLE;
      cmderr_d   = ERR_NONE;
      data0_we_d = 1'b0;
      rf_req_d   = 1'b0;
      rf_we_d    = 1'b0;
      csr_req_d  = 1'b0;
      csr_we_d   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      cmderr_q   <= ERR_NONE;
      data0_q    <= '0;
      data0_we_q <= 1'b0;
      busy_q     <= 1'b0;
      rf_req_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      csr_req_q  <= 1'b0;
      csr_we_q   <= 1'b0;
      csr_addr_q <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cmderr_q   <= cmderr_d;
      data0_q    <= data0_d;
      data0_we_q <= data0_we_d;
      busy_q     <= busy_d;
      rf_req_q   <= rf_req_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      csr_req_q  <= csr_req_d;
      csr_we_q   <= csr_we_d;
      csr_addr_q <= csr_addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign oData0    = data0_q;
  assign oData0We  = data0_we_q;
  assign oBusy     = busy_q;
  assign oCmdErr   = cmderr_q;
  assign oRfReq    = rf_req_q;
  assign oRfWe     = rf_we_q;
  assign oRfAddr   = rf_addr_q;
  assign oRfWdata  = wdata_q;
  assign oCsrReq   = csr_req_q;
  assign oCsrWe    = csr_we_q;
  assign oCsrAddr  = csr_addr_q;
  assign oCsrWdata = wdata_q;

endmodule

// File: doc/dm_abstract_cmd.md
# dm_abstract_cmd

Abstract-command sequencer for the debug module. It accepts Access Register commands from the DMI command register and runs them against the halted hart's register file or CSR file over the two debug-access buses. It also owns abstractcs `busy`/`cmderr` and the data0 transfer. It sits between the DM register block (which decodes DMI writes) and the `dbac_rf` / `dbac_csr` bus masters.

## Interface
- `TIMEOUT_CYCLES`, 255: bus-watchdog limit in cycles. Used only when `DM_ABS_TIMEOUT_EN` is defined.
- `iClk`  in  1  clock, single domain.
- `iRst_n`  in  1  asynchronous, active-low reset.
- `iDmActive`  in  1  dmcontrol.dmactive. Low means synchronous soft reset of this block.
- `iHalted`  in  1  hart halted (allhalted).
- `iCmdValid`  in  1  one-cycle pulse: DMI wrote the command register.
- `iCmd`  in  32  command word: cmdtype[31:24], aarsize[22:20], postexec[18], transfer[17], write[16], regno[15:0].
- `iErrClr`  in  3  W1C mask for cmderr, valid for one cycle.
- `iData0`  in  32  current data0 (write source).
- `oData0`  out  32  data0 load value.
- `oData0We`  out  1  one-cycle data0 load strobe.
- `oBusy`  out  1  abstractcs.busy.
- `oCmdErr`  out  3  abstractcs.cmderr.
- `oRfReq`, `oRfWe`  out  1 each  register-file request and write enable.
- `oRfAddr`  out  5  register-file address.
- `oRfWdata`  out  32  register-file write data.
- `iRfAck`, `iRfErr`  in  1 each  register-file completion and error.
- `iRfRdata`  in  32  register-file read data.
- `oCsrReq`, `oCsrWe`  out  1 each  CSR request and write enable.
- `oCsrAddr`  out  12  CSR address.
- `oCsrWdata`  out  32  CSR write data.
- `iCsrAck`, `iCsrErr`  in  1 each  CSR completion and error.
- `iCsrRdata`  in  32  CSR read data.

## Operation
- FSM states: IDLE, DECODE, REQ, DONE.
- IDLE -> DECODE: on `iCmdValid` when `oCmdErr==0`. The command word is latched.
- `iCmdValid` in IDLE with `oCmdErr!=0`: ignored, no state change.
- DECODE checks, in priority order; the first failing check sets cmderr and the FSM goes to DONE:
  1. cmdtype!=0 -> 2 (notsupported).
  2. aarsize!=2 -> 2.
  3. postexec=1 -> 2.
  4. transfer=1 and regno not in 0x0000–0x0FFF or 0x1000–0x101F -> 2.
  5. `iHalted`=0 -> 4 (haltresume).
  6. transfer=0 -> DONE, no error.
  7. Otherwise -> REQ.
- Address routing: regno 0x0000–0x0FFF goes to CSR with `oCsrAddr`=regno[11:0]. Regno 0x1000–0x101F goes to RF with `oRfAddr`=regno[4:0].
- REQ: exactly one of `oRfReq`/`oCsrReq` is held high, with We=write and Wdata=`iData0` (latched at DECODE), until ack.
- Ack without Err: on a read, the rdata is captured into `oData0`, then DONE.
- Ack with Err: cmderr=3 (exception), `oData0` unchanged, then DONE.
- DONE: `oData0We`=1 for this cycle only, and only for a successful read. Then IDLE.
- `iCmdValid` in DECODE/REQ/DONE: if cmderr==0, set cmderr=1 (busy). The command is discarded and the running command continues. A later bus error does not overwrite cmderr.
- cmderr is sticky. It clears only via `iErrClr` (bitwise W1C) or `iDmActive`=0.
- If `iErrClr` and an error set land in the same cycle, the set wins.
- `iDmActive`=0 (synchronous): FSM -> IDLE, all requests drop, cmderr=0, `oData0We`=0.
- The abandoned bus transaction is not retried. A late ack in IDLE is ignored.

## Timing
- Reset values: FSM IDLE, `oBusy`=0, `oCmdErr`=0, `oData0`=0, `oData0We`=0, all Req/We=0, all addresses and wdata=0.
- `oBusy`=1 in DECODE, REQ and DONE; `oBusy`=0 in IDLE. It rises in the cycle after `iCmdValid`.
- Acks are sampled at the clock edge. Req deasserts in the cycle after ack.
- Minimum latency, `iCmdValid` to `oBusy` low: 4 cycles (ack in the first REQ cycle).
- Latency for an error or transfer=0 command: 3 cycles.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `DM_ABS_TIMEOUT_EN` defined: a counter runs while in REQ. After `TIMEOUT_CYCLES` cycles with no ack, Req drops, cmderr=5 (bus), and the FSM goes to DONE. The counter clears on entry to REQ.
- `DM_ABS_TIMEOUT_EN` undefined: REQ waits indefinitely, and the only exit without an ack is `iDmActive`=0.

## Test plan
- Halted, cmd 0x0022_1001 (read x1), RF acks next cycle with rdata 0xDEAD_BEEF -> `oRfReq` held 1 cycle, `oData0`=0xDEADBEEF, `oData0We` pulses in DONE, `oBusy` low 4 cycles after the command, cmderr=0.
- Halted, cmd 0x0023_0300 (write CSR 0x300), `iData0`=0x1888 -> `oCsrWe`=1, `oCsrAddr`=0x300, `oCsrWdata`=0x1888, no `oData0We`.
- Running hart, cmd 0x0022_1002 -> no Req, cmderr=4. A following command is ignored until `iErrClr`=3'b111, after which cmderr=0.
- Illegal commands aarsize=3, regno 0x1020, cmdtype=1 -> cmderr=2, no bus access. `iCsrErr` on ack -> cmderr=3.
- RF ack stalled 10 cycles, second `iCmdValid` at cycle 3 -> cmderr=1, the first command completes normally, and the second command produces no access.
- With `DM_ABS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, no ack -> Req drops after 16 cycles, cmderr=5. Separately, `iDmActive` low during REQ -> IDLE next cycle, cmderr=0.
